// File: rtl/pipe_ctrl_pred_pkg.sv
// pipe_ctrl_pred_pkg: shared constants for the pipelined control path.
//   - MIPS-style opcode and R-type funct encodings
//   - ALU operation codes (3-bit; zero-extended by users to their own width)
//   - control-word field layouts and widths for the D, E, M and W stages
package pipe_ctrl_pred_pkg;

   localparam int unsigned OP_W       = 6;
   localparam int unsigned FUNCT_W    = 6;
   localparam int unsigned ALU_CODE_W = 3;

   // Opcodes
   localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
   localparam logic [OP_W-1:0] OP_J     = 6'h02;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
   localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
   localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
   localparam logic [OP_W-1:0] OP_LW    = 6'h23;
   localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

   // R-type funct codes
   localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
   localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
   localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
   localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
   localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

   // ALU operation codes
   localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'd0;
   localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'd1;
   localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'd2;
   localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'd6;
   localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'd7;

   // Single-bit controls produced by decode (alucontrol travels separately
   // because its width is a parameter of the users).
   typedef struct packed {
      logic memtoreg;
      logic memwrite;
      logic alusrc;
      logic regdst;
      logic regwrite;
      logic branch;
      logic bne;
      logic jump;
   } dec_flags_t;

   // D->E register flags (jump is resolved in D and not carried).
   typedef struct packed {
      logic memtoreg;
      logic memwrite;
      logic alusrc;
      logic regdst;
      logic regwrite;
      logic branch;
      logic bne;
      logic predict_taken;
   } e_flags_t;

   // E->M register: only what memory and writeback still need.
   typedef struct packed {
      logic memtoreg;
      logic memwrite;
      logic regwrite;
   } m_flags_t;

   // M->W register.
   typedef struct packed {
      logic memtoreg;
      logic regwrite;
   } w_flags_t;

   localparam int unsigned DEC_FLAGS_W = $bits(dec_flags_t);
   localparam int unsigned E_FLAGS_W   = $bits(e_flags_t);
   localparam int unsigned M_FLAGS_W   = $bits(m_flags_t);
   localparam int unsigned W_FLAGS_W   = $bits(w_flags_t);

endpackage

// File: rtl/pipe_ctrl_pred_ctrl_decode.sv
// ctrl_decode: combinational opcode/funct -> control word decoder.
//   op_i          decode-stage opcode
//   funct_i       decode-stage funct field (used for R-type only)
//   flags_o       single-bit controls (memtoreg, memwrite, alusrc, regdst,
//                 regwrite, branch, bne, jump)
//   alucontrol_o  ALU operation, zero-extended to ALUCTRL_W
// Any unrecognised opcode/funct (and the extended ops when EXT_OPS=0)
// produces an all-zero control word.
module ctrl_decode
   import pipe_ctrl_pred_pkg::*;
#(
   parameter int unsigned ALUCTRL_W = 3,
   parameter int unsigned EXT_OPS   = 1
) (
   input  logic [OP_W-1:0]      op_i,
   input  logic [FUNCT_W-1:0]   funct_i,
   output dec_flags_t           flags_o,
   output logic [ALUCTRL_W-1:0] alucontrol_o
);

   logic [ALU_CODE_W-1:0] alu_code;
   logic                  r_legal;

   // R-type funct decode
   always_comb begin
      r_legal  = 1'b1;
      alu_code = ALU_AND;
      case (funct_i)
         FUNCT_ADD: alu_code = ALU_ADD;
         FUNCT_SUB: alu_code = ALU_SUB;
         FUNCT_AND: alu_code = ALU_AND;
         FUNCT_OR:  alu_code = ALU_OR;
         FUNCT_SLT: alu_code = ALU_SLT;
         default:   r_legal  = 1'b0;
      endcase
   end

   logic [ALU_CODE_W-1:0] alu_sel;

   always_comb begin
      flags_o = '0;
      alu_sel = '0;
      case (op_i)
         OP_RTYPE: begin
            if (r_legal) begin
               flags_o.regwrite = 1'b1;
               flags_o.regdst   = 1'b1;
               alu_sel          = alu_code;
            end
         end
         OP_LW: begin
            flags_o.memtoreg = 1'b1;
            flags_o.alusrc   = 1'b1;
            flags_o.regwrite = 1'b1;
            alu_sel          = ALU_ADD;
         end
         OP_SW: begin
            flags_o.memwrite = 1'b1;
            flags_o.alusrc   = 1'b1;
            alu_sel          = ALU_ADD;
         end
         OP_BEQ: begin
            flags_o.branch = 1'b1;
            alu_sel        = ALU_SUB;
         end
         OP_J: begin
            flags_o.jump = 1'b1;
         end
         OP_ADDI: begin
            if (EXT_OPS != 0) begin
               flags_o.alusrc   = 1'b1;
               flags_o.regwrite = 1'b1;
               alu_sel          = ALU_ADD;
            end
         end
         OP_ANDI: begin
            if (EXT_OPS != 0) begin
               flags_o.alusrc   = 1'b1;
               flags_o.regwrite = 1'b1;
               alu_sel          = ALU_AND;
            end
         end
         OP_ORI: begin
            if (EXT_OPS != 0) begin
               flags_o.alusrc   = 1'b1;
               flags_o.regwrite = 1'b1;
               alu_sel          = ALU_OR;
            end
         end
         OP_BNE: begin
            if (EXT_OPS != 0) begin
               flags_o.branch = 1'b1;
               flags_o.bne    = 1'b1;
               alu_sel        = ALU_SUB;
            end
         end
         default: ;
      endcase
   end

   // ALUCTRL_W is expected to be at least ALU_CODE_W; wider fields are zero-filled.
   assign alucontrol_o = ALUCTRL_W'(alu_sel);

endmodule

// File: rtl/pipe_ctrl_pred.sv
// pipe_ctrl_pred: pipelined control path with static branch prediction
// feedback and branch/mispredict statistics.
//   clk, rst                 clock, async active-high reset
//   opD, functD              decode-stage instruction fields
//   predict_takenD           predictor guess for the D instruction
//   zeroE                    ALU zero flag of the E instruction
//   stallE/stallM            hold E / M registers (stallM also holds E)
//   flushE/flushM            bubble E / M registers (beats stall)
//   cnt_clr                  synchronous clear of both counters
//   branchD..pred_redirectD  combinational D-stage decode results
//   *E, *M, *W               registered per-stage controls
//   mispredictE              branch in E resolved opposite to its prediction
//   actual_takenE            resolved branch direction in E
//   branch_cnt/mispredict_cnt  saturating statistics counters
module pipe_ctrl_pred
   import pipe_ctrl_pred_pkg::*;
#(
   parameter int unsigned ALUCTRL_W = 3,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned EXT_OPS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OP_W-1:0]      opD,
   input  logic [FUNCT_W-1:0]   functD,
   input  logic                 predict_takenD,
   input  logic                 zeroE,
   input  logic                 stallE,
   input  logic                 stallM,
   input  logic                 flushE,
   input  logic                 flushM,
   input  logic                 cnt_clr,
   output logic                 branchD,
   output logic                 bneD,
   output logic                 jumpD,
   output logic                 pred_redirectD,
   output logic                 memtoregE,
   output logic                 alusrcE,
   output logic                 regdstE,
   output logic                 regwriteE,
   output logic [ALUCTRL_W-1:0] alucontrolE,
   output logic                 mispredictE,
   output logic                 actual_takenE,
   output logic                 memtoregM,
   output logic                 memwriteM,
   output logic                 regwriteM,
   output logic                 memtoregW,
   output logic                 regwriteW,
   output logic [CNT_W-1:0]     branch_cnt,
   output logic [CNT_W-1:0]     mispredict_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   dec_flags_t           dec_flags;
   logic [ALUCTRL_W-1:0] dec_alu;

   ctrl_decode #(
      .ALUCTRL_W (ALUCTRL_W),
      .EXT_OPS   (EXT_OPS)
   ) u_ctrl_decode (
      .op_i         (opD),
      .funct_i      (functD),
      .flags_o      (dec_flags),
      .alucontrol_o (dec_alu)
   );

   e_flags_t             e_q, e_d;
   logic [ALUCTRL_W-1:0] alu_e_q, alu_e_d;
   m_flags_t             m_q, m_d;
   w_flags_t             w_q, w_d;
   logic [CNT_W-1:0]     branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]     mispredict_cnt_q, mispredict_cnt_d;

   logic hold_e;
   logic actual_taken;
   logic mispredict;

   // A stalled M would otherwise be overwritten by E, so E must hold too.
   assign hold_e = stallE | stallM;

   assign actual_taken = (e_q.bne ? ~zeroE : zeroE) & e_q.branch;
   assign mispredict   = e_q.branch & (actual_taken != e_q.predict_taken);

   always_comb begin
      e_d     = e_q;
      alu_e_d = alu_e_q;
      if (flushE) begin
         e_d     = '0;
         alu_e_d = '0;
      end else if (!hold_e) begin
         e_d.memtoreg      = dec_flags.memtoreg;
         e_d.memwrite      = dec_flags.memwrite;
         e_d.alusrc        = dec_flags.alusrc;
         e_d.regdst        = dec_flags.regdst;
         e_d.regwrite      = dec_flags.regwrite;
         e_d.branch        = dec_flags.branch;
         e_d.bne           = dec_flags.bne;
         e_d.predict_taken = predict_takenD;
         alu_e_d           = dec_alu;
      end
   end

   always_comb begin
      m_d = m_q;
      if (flushM) begin
         m_d = '0;
      end else if (stallM) begin
         m_d = m_q;
      end else if (stallE) begin
         // E is holding its instruction; passing it on too would duplicate it.
         m_d = '0;
      end else begin
         m_d.memtoreg = e_q.memtoreg;
         m_d.memwrite = e_q.memwrite;
         m_d.regwrite = e_q.regwrite;
      end
   end

   always_comb begin
      w_d.memtoreg = m_q.memtoreg;
      w_d.regwrite = m_q.regwrite;
   end

   always_comb begin
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (cnt_clr) begin
         branch_cnt_d     = '0;
         mispredict_cnt_d = '0;
      end else if (!stallE) begin
         if (e_q.branch && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
         end
         if (mispredict && (mispredict_cnt_q != CNT_MAX)) begin
            mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_q              <= '0;
         alu_e_q          <= '0;
         m_q              <= '0;
         w_q              <= '0;
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         e_q              <= e_d;
         alu_e_q          <= alu_e_d;
         m_q              <= m_d;
         w_q              <= w_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign branchD        = dec_flags.branch;
   assign bneD           = dec_flags.bne;
   assign jumpD          = dec_flags.jump;
   assign pred_redirectD = dec_flags.branch & predict_takenD;

   assign memtoregE     = e_q.memtoreg;
   assign alusrcE       = e_q.alusrc;
   assign regdstE       = e_q.regdst;
   assign regwriteE     = e_q.regwrite;
   assign alucontrolE   = alu_e_q;
   assign mispredictE   = mispredict;
   assign actual_takenE = actual_taken;

   assign memtoregM = m_q.memtoreg;
   assign memwriteM = m_q.memwrite;
   assign regwriteM = m_q.regwrite;

   assign memtoregW = w_q.memtoreg;
   assign regwriteW = w_q.regwrite;

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_pred.sv
// Bench for pipe_ctrl_pred: a default instance (EXT_OPS=1, CNT_W=16) and a
// reduced instance (EXT_OPS=0, CNT_W=2) share one stimulus stream and are
// checked against an instruction-level reference model.
module tb_pipe_ctrl_pred;

   logic       clk;
   logic       rst;
   logic [5:0] opD;
   logic [5:0] functD;
   logic       predict_takenD, zeroE, stallE, stallM, flushE, flushM, cnt_clr;

   // instance 0 outputs
   logic        brD0, bneD0, jD0, prD0, mtrE0, asE0, rdE0, rwE0, misE0, atE0;
   logic [2:0]  aluE0;
   logic        mtrM0, mwM0, rwM0, mtrW0, rwW0;
   logic [15:0] bcnt0, mcnt0;
   // instance 1 outputs
   logic        brD1, bneD1, jD1, prD1, mtrE1, asE1, rdE1, rwE1, misE1, atE1;
   logic [2:0]  aluE1;
   logic        mtrM1, mwM1, rwM1, mtrW1, rwW1;
   logic [1:0]  bcnt1, mcnt1;

   pipe_ctrl_pred u_dut (
      .clk (clk), .rst (rst), .opD (opD), .functD (functD),
      .predict_takenD (predict_takenD), .zeroE (zeroE),
      .stallE (stallE), .stallM (stallM), .flushE (flushE), .flushM (flushM),
      .cnt_clr (cnt_clr),
      .branchD (brD0), .bneD (bneD0), .jumpD (jD0), .pred_redirectD (prD0),
      .memtoregE (mtrE0), .alusrcE (asE0), .regdstE (rdE0), .regwriteE (rwE0),
      .alucontrolE (aluE0), .mispredictE (misE0), .actual_takenE (atE0),
      .memtoregM (mtrM0), .memwriteM (mwM0), .regwriteM (rwM0),
      .memtoregW (mtrW0), .regwriteW (rwW0),
      .branch_cnt (bcnt0), .mispredict_cnt (mcnt0)
   );

   pipe_ctrl_pred #(.CNT_W (2), .EXT_OPS (0)) u_small (
      .clk (clk), .rst (rst), .opD (opD), .functD (functD),
      .predict_takenD (predict_takenD), .zeroE (zeroE),
      .stallE (stallE), .stallM (stallM), .flushE (flushE), .flushM (flushM),
      .cnt_clr (cnt_clr),
      .branchD (brD1), .bneD (bneD1), .jumpD (jD1), .pred_redirectD (prD1),
      .memtoregE (mtrE1), .alusrcE (asE1), .regdstE (rdE1), .regwriteE (rwE1),
      .alucontrolE (aluE1), .mispredictE (misE1), .actual_takenE (atE1),
      .memtoregM (mtrM1), .memwriteM (mwM1), .regwriteM (rwM1),
      .memtoregW (mtrW1), .regwriteW (rwW1),
      .branch_cnt (bcnt1), .mispredict_cnt (mcnt1)
   );

   // Observed vectors: 4 D bits, then 14 bits of E/M/W state.
   logic [17:0] obs0, obs1;
   assign obs0 = {brD0, bneD0, jD0, prD0, mtrE0, asE0, rdE0, rwE0, aluE0, misE0, atE0,
                  mtrM0, mwM0, rwM0, mtrW0, rwW0};
   assign obs1 = {brD1, bneD1, jD1, prD1, mtrE1, asE1, rdE1, rwE1, aluE1, misE1, atE1,
                  mtrM1, mwM1, rwM1, mtrW1, rwW1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // ---------------- reference model ----------------
   typedef struct packed {
      logic memtoreg, memwrite, alusrc, regdst, regwrite, branch, bne, jump;
      logic [2:0] alu;
   } dec_t;

   typedef struct packed {
      logic memtoreg, memwrite, alusrc, regdst, regwrite, branch, bne, pt;
      logic [2:0] alu;
   } instr_t;

   instr_t     me [2];
   logic [2:0] mm [2];   // {memtoreg, memwrite, regwrite}
   logic [1:0] mw [2];   // {memtoreg, regwrite}
   int         cb [2];
   int         cm [2];
   int         cmax [2] = '{65535, 3};
   bit         mext [2] = '{1'b1, 1'b0};

   function automatic dec_t ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                       input bit ext);
      dec_t d;
      d = '0;
      if (op == 6'h00) begin
         d.regwrite = 1'b1;
         d.regdst   = 1'b1;
         if      (fn == 6'h20) d.alu = 3'd2;
         else if (fn == 6'h22) d.alu = 3'd6;
         else if (fn == 6'h24) d.alu = 3'd0;
         else if (fn == 6'h25) d.alu = 3'd1;
         else if (fn == 6'h2A) d.alu = 3'd7;
         else                  d = '0;
      end else if (op == 6'h23) begin
         d.memtoreg = 1'b1; d.alusrc = 1'b1; d.regwrite = 1'b1; d.alu = 3'd2;
      end else if (op == 6'h2B) begin
         d.memwrite = 1'b1; d.alusrc = 1'b1; d.alu = 3'd2;
      end else if (op == 6'h04) begin
         d.branch = 1'b1; d.alu = 3'd6;
      end else if (op == 6'h02) begin
         d.jump = 1'b1;
      end else if (ext && op == 6'h05) begin
         d.branch = 1'b1; d.bne = 1'b1; d.alu = 3'd6;
      end else if (ext && (op == 6'h08 || op == 6'h0C || op == 6'h0D)) begin
         d.alusrc   = 1'b1;
         d.regwrite = 1'b1;
         d.alu      = (op == 6'h08) ? 3'd2 : (op == 6'h0C) ? 3'd0 : 3'd1;
      end
      return d;
   endfunction

   function automatic logic [17:0] exp_vec(input int i);
      dec_t d;
      logic at, mp;
      d  = ref_decode(opD, functD, mext[i]);
      at = me[i].branch && (me[i].bne ? !zeroE : zeroE);
      mp = me[i].branch && (at != me[i].pt);
      return {d.branch, d.bne, d.jump, d.branch & predict_takenD,
              me[i].memtoreg, me[i].alusrc, me[i].regdst, me[i].regwrite, me[i].alu,
              mp, at, mm[i], mw[i]};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         me[i] = '0; mm[i] = '0; mw[i] = '0; cb[i] = 0; cm[i] = 0;
      end
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      instr_t     oe;
      logic [2:0] om;
      dec_t       d;
      logic       at, mp;
      if (rst) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         oe = me[i];
         om = mm[i];
         d  = ref_decode(opD, functD, mext[i]);
         at = oe.branch && (oe.bne ? !zeroE : zeroE);
         mp = oe.branch && (at != oe.pt);
         if (cnt_clr) begin
            cb[i] = 0; cm[i] = 0;
         end else if (!stallE) begin
            if (oe.branch && cb[i] < cmax[i]) cb[i]++;
            if (mp && cm[i] < cmax[i]) cm[i]++;
         end
         if (flushE) me[i] = '0;
         else if (!(stallE || stallM)) begin
            me[i].memtoreg = d.memtoreg; me[i].memwrite = d.memwrite;
            me[i].alusrc   = d.alusrc;   me[i].regdst   = d.regdst;
            me[i].regwrite = d.regwrite; me[i].branch   = d.branch;
            me[i].bne      = d.bne;      me[i].pt       = predict_takenD;
            me[i].alu      = d.alu;
         end
         if (flushM) mm[i] = '0;
         else if (stallM) mm[i] = om;
         else if (stallE) mm[i] = '0;
         else mm[i] = {oe.memtoreg, oe.memwrite, oe.regwrite};
         mw[i] = {om[2], om[0]};
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_idle();
      opD = 6'h3F; functD = 6'h00; predict_takenD = 1'b0; zeroE = 1'b0;
      stallE = 1'b0; stallM = 1'b0; flushE = 1'b0; flushM = 1'b0; cnt_clr = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2;
      n_vec++;
      if (obs0[13:0] !== 14'd0 || bcnt0 !== 16'd0 || mcnt0 !== 16'd0) begin
         n_err++;
         $display("FAIL reset_state: got %b cnt %0d/%0d want all zero", obs0[13:0], bcnt0, mcnt0);
      end
      n_vec++;
      if (obs1 !== exp_vec(1)) begin
         n_err++; $display("FAIL reset_small: got %b want %b", obs1, exp_vec(1));
      end
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_lw();
      opD = 6'h23;
      tick();
      set_idle();
      #1;
      n_vec++;
      if ({mtrE0, asE0, aluE0} !== {1'b1, 1'b1, 3'd2}) begin
         n_err++; $display("FAIL lw_e: got %b want 11010", {mtrE0, asE0, aluE0});
      end
      tick();
      n_vec++;
      if (mtrM0 !== 1'b1) begin
         n_err++; $display("FAIL lw_m: memtoregM got %b want 1", mtrM0);
      end
      tick();
      n_vec++;
      if (rwW0 !== 1'b1 || obs0 !== exp_vec(0)) begin
         n_err++; $display("FAIL lw_w: got %b want %b", obs0, exp_vec(0));
      end
   endtask

   task automatic test_beq_mispredict();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      opD = 6'h04; predict_takenD = 1'b0;
      #1;
      n_vec++;
      if (brD0 !== 1'b1 || prD0 !== 1'b0) begin
         n_err++; $display("FAIL beq_d: branchD %b redirect %b want 1 0", brD0, prD0);
      end
      tick();
      set_idle();
      zeroE = 1'b1;
      #1;
      n_vec++;
      if (atE0 !== 1'b1 || misE0 !== 1'b1 || obs0 !== exp_vec(0)) begin
         n_err++; $display("FAIL beq_e: taken %b mis %b want 1 1", atE0, misE0);
      end
      tick();
      zeroE = 1'b0;
      n_vec++;
      if (bcnt0 !== 16'd1 || mcnt0 !== 16'd1) begin
         n_err++; $display("FAIL beq_cnt: got %0d/%0d want 1/1", bcnt0, mcnt0);
      end
   endtask

   task automatic test_bne();
      opD = 6'h05; predict_takenD = 1'b1; zeroE = 1'b0;
      #1;
      n_vec++;
      if ({brD0, bneD0, prD0, brD1, prD1} !== 5'b11100) begin
         n_err++; $display("FAIL bne_d: got %b want 11100", {brD0, bneD0, prD0, brD1, prD1});
      end
      tick();
      set_idle();
      #1;
      n_vec++;
      if (misE0 !== 1'b0 || atE0 !== 1'b1) begin
         n_err++; $display("FAIL bne_e: mis %b taken %b want 0 1", misE0, atE0);
      end
      n_vec++;
      if ({mtrE1, asE1, rdE1, rwE1, aluE1, misE1} !== 8'd0 || obs1 !== exp_vec(1)) begin
         n_err++; $display("FAIL bne_noext: got %b want %b", obs1, exp_vec(1));
      end
   endtask

   task automatic test_stall_sub();
      opD = 6'h00; functD = 6'h22;
      tick();
      opD = 6'h23; stallE = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_vec++;
         if (aluE0 !== 3'd6 || rwM0 !== 1'b0) begin
            n_err++; $display("FAIL stall_sub_%0d: alu %0d rwM %b want 6 0", k, aluE0, rwM0);
         end
      end
      stallE = 1'b0;
      tick();
      n_vec++;
      if (rwM0 !== 1'b1 || obs0 !== exp_vec(0)) begin
         n_err++; $display("FAIL stall_release: got %b want %b", obs0, exp_vec(0));
      end
      set_idle();
   endtask

   task automatic test_flush_stall_reset();
      opD = 6'h00; functD = 6'h20;
      tick();
      flushE = 1'b1; stallE = 1'b1;
      tick();
      n_vec++;
      if (rwE0 !== 1'b0 || aluE0 !== 3'd0) begin
         n_err++; $display("FAIL flush_stall: rwE %b alu %0d want 0 0", rwE0, aluE0);
      end
      set_idle();
      opD = 6'h23;
      tick();
      tick();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_vec++;
      if (obs0[13:0] !== 14'd0 || bcnt0 !== 16'd0 || mcnt0 !== 16'd0) begin
         n_err++;
         $display("FAIL async_reset: got %b cnt %0d/%0d want 0", obs0[13:0], bcnt0, mcnt0);
      end
      tick();
      rst = 1'b0;
      tick();
      n_vec++;
      if (mtrE0 !== 1'b1 || obs0 !== exp_vec(0)) begin
         n_err++; $display("FAIL post_reset_load: got %b want %b", obs0, exp_vec(0));
      end
      set_idle();
   endtask

   task automatic test_saturate();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      opD = 6'h04;
      for (int k = 0; k < 5; k++) tick();
      set_idle();
      tick();
      n_vec++;
      if (bcnt1 !== 2'd3 || bcnt0 !== 16'd5) begin
         n_err++; $display("FAIL saturate: got %0d/%0d want 3/5", bcnt1, bcnt0);
      end
      opD = 6'h04;
      tick();
      set_idle();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      n_vec++;
      if (bcnt1 !== 2'd0 || bcnt0 !== 16'd0) begin
         n_err++; $display("FAIL clr_wins: got %0d/%0d want 0/0", bcnt1, bcnt0);
      end
   endtask

   task automatic test_random();
      logic [5:0] ops [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
                               6'h23, 6'h2B, 6'h3F};
      logic [5:0] fns [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h11};
      for (int k = 0; k < 400; k++) begin
         opD    = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
         functD = fns[$urandom_range(0, 5)];
         predict_takenD = 1'($urandom);
         zeroE   = 1'($urandom);
         stallE  = ($urandom_range(0, 4) == 0);
         stallM  = ($urandom_range(0, 7) == 0);
         flushE  = ($urandom_range(0, 9) == 0);
         flushM  = ($urandom_range(0, 9) == 0);
         cnt_clr = ($urandom_range(0, 39) == 0);
         #1;
         n_vec++;
         if (obs0 !== exp_vec(0)) begin
            n_err++; $display("FAIL rand_main@%0d: got %b want %b", k, obs0, exp_vec(0));
         end
         n_vec++;
         if (obs1 !== exp_vec(1)) begin
            n_err++; $display("FAIL rand_small@%0d: got %b want %b", k, obs1, exp_vec(1));
         end
         n_vec++;
         if (bcnt0 !== 16'(cb[0]) || mcnt0 !== 16'(cm[0])) begin
            n_err++;
            $display("FAIL rand_cnt_main@%0d: got %0d/%0d want %0d/%0d", k, bcnt0, mcnt0,
                     cb[0], cm[0]);
         end
         n_vec++;
         if (bcnt1 !== 2'(cb[1]) || mcnt1 !== 2'(cm[1])) begin
            n_err++;
            $display("FAIL rand_cnt_small@%0d: got %0d/%0d want %0d/%0d", k, bcnt1, mcnt1,
                     cb[1], cm[1]);
         end
         tick();
      end
      set_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      set_idle();
      model_reset();
      test_reset();
      test_lw();
      test_beq_mispredict();
      test_bne();
      test_stall_sub();
      test_flush_stall_reset();
      test_saturate();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_pred.md
PIPE_CTRL_PRED -- requirements
Module: pipe_ctrl_pred

Interface
REQ-001 Parameter ALUCTRL_W, default 3: width of the ALU control field.
REQ-002 Parameter CNT_W, default 16: width of the branch and mispredict statistics counters.
REQ-003 Parameter EXT_OPS, default 1: 1 enables decode of addi/andi/ori/bne; 0 decodes these as illegal, producing an all-zero control word.
REQ-004 The port list SHALL be, in order (name, direction, width, meaning):
- clk in 1: the block's one clock.
- rst in 1: asynchronous, active-high reset.
- opD in 6: decode-stage opcode.
- functD in 6: decode-stage funct field.
- predict_takenD in 1: branch predictor's taken guess for the D instruction.
- zeroE in 1: ALU zero flag of the E instruction.
- stallE, stallM in 1: hold the E / M pipeline register.
- flushE, flushM in 1: bubble the E / M pipeline register.
- cnt_clr in 1: synchronous clear of both counters.
- branchD, bneD, jumpD out 1: decoded branch, bne and jump.
- pred_redirectD out 1: fetch redirect to the predicted target.
- memtoregE, alusrcE, regdstE, regwriteE out 1: E-stage controls.
- alucontrolE out ALUCTRL_W: E-stage ALU operation.
- mispredictE out 1: flush request plus PC recovery in E.
- actual_takenE out 1: resolved branch direction in E.
- memtoregM, memwriteM, regwriteM out 1: M-stage controls.
- memtoregW, regwriteW out 1: W-stage controls.
- branch_cnt, mispredict_cnt out CNT_W: statistics counters.

Function
REQ-005 Decode SHALL be combinational in D and cover R-type add/sub/and/or/slt, lw, sw, beq and j, plus addi/andi/ori/bne when EXT_OPS=1.
REQ-006 ALU codes SHALL be: and=0, or=1, add=2, sub=6, slt=7, zero-extended to ALUCTRL_W. beq/bne use sub; addi/lw/sw use add.
REQ-007 pred_redirectD SHALL equal branchD & predict_takenD. The block SHALL NOT use any D-stage equality compare.
REQ-008 The D->E register SHALL carry memtoreg, memwrite, alusrc, regdst, regwrite, alucontrol, branch, bne and predict_taken.
REQ-009 The E->M and M->W registers SHALL carry only the fields used downstream.
REQ-010 Per-stage priority SHALL be flush > stall > load.
- A flushed stage loads all-zero (bubble) on the next edge.
- A stalled stage holds its value.
REQ-011 When stallE=1, stallM=0 and flushM=0, M SHALL load a bubble so that no E instruction is duplicated.
REQ-012 When stallM=1, E SHALL also hold, even if stallE=0.
REQ-013 W SHALL never stall and SHALL load from M every cycle.
REQ-014 actual_takenE SHALL equal (bneE ? ~zeroE : zeroE) & branchE.
REQ-015 mispredictE SHALL equal branchE & (actual_takenE != predict_takenE), combinational, valid in the same cycle the branch is in E.
REQ-016 mispredictE SHALL NOT internally flush E. The hazard unit feeds flushE; this block only reports the mispredict.
REQ-017 branch_cnt SHALL increment on each edge where branchE=1 and stallE=0. Saturating: the counter holds at all-ones.
REQ-018 mispredict_cnt SHALL increment on each edge where mispredictE=1 and stallE=0. Saturating.
REQ-019 When cnt_clr=1, both counters SHALL be zeroed on the next edge. cnt_clr wins over a simultaneous increment.
REQ-020 Latency SHALL be: D decode appears in E controls 1 cycle later, M 2 cycles later, W 3 cycles later, absent stall or flush.

Reset
REQ-021 rst=1 SHALL asynchronously zero every pipeline register and both counters. All E/M/W outputs, mispredictE and actual_takenE then read 0.
REQ-022 A reset asserted mid-operation SHALL discard in-flight instructions with no partial update. The first post-reset edge loads D normally.

Structure
REQ-023 Opcode/funct constants and the ALU code constants SHALL reside in a shared package, together with the control-word field widths.
REQ-024 One sub-module, ctrl_decode (opcode/funct -> control word, parametrised by ALUCTRL_W and EXT_OPS), SHALL hold all decode logic. Pipeline registers stay in pipe_ctrl_pred.

Verification
REQ-025 lw (op 0x23) with no stall: memtoregE=1, alusrcE=1, alucontrolE=2 at cycle+1; memtoregM=1 at cycle+2; regwriteW=1 at cycle+3.
REQ-026 beq, predict_takenD=0, then zeroE=1 in E: actual_takenE=1 and mispredictE=1; next edge branch_cnt=1 and mispredict_cnt=1.
REQ-027 bne, predict_takenD=1, zeroE=0: mispredictE=0. With EXT_OPS=0, bne yields branchD=0 and an all-zero E control word.
REQ-028 R-type sub with stallE=1 for 2 cycles: E holds alucontrolE=6; M shows regwriteM=0 for 2 cycles, then 1.
REQ-029 flushE=1 and stallE=1 together: E becomes a bubble (regwriteE=0). rst pulsed mid-stream: all outputs read 0 immediately, before any clock edge.
REQ-030 With CNT_W=2, drive 5 beq: branch_cnt saturates at 3. Then cnt_clr=1 together with a branch in E: branch_cnt=0.
